// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings plus the combinational control decoder and immediate extender
package decode_pkg;
    localparam logic [1:0] RS_ALU = 2'b00, RS_MEM = 2'b01, RS_PC4 = 2'b10;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4, ALU_SLT = 3'd5, ALU_SLL = 3'd6, ALU_SRL = 3'd7;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic [2:0] imm_src;
    } ctrl_t;

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2,
            3'd3:    return ALU_SLT;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Unsupported opcodes fall to all-zero controls, which also selects the I-format immediate
    function automatic ctrl_t decode(input logic [31:0] i);
        case (i[6:0])
            OP_R:      return '{1'b1, RS_ALU, 1'b0, 1'b0, 1'b0, alu_op(i[14:12], i[30]), 1'b0, IMM_I};
            OP_I:      return '{1'b1, RS_ALU, 1'b0, 1'b0, 1'b0, alu_op(i[14:12], 1'b0), 1'b1, IMM_I};
            OP_LOAD:   return '{1'b1, RS_MEM, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1, IMM_I};
            OP_STORE:  return '{1'b0, RS_ALU, 1'b1, 1'b0, 1'b0, ALU_ADD, 1'b1, IMM_S};
            OP_BRANCH: return '{1'b0, RS_ALU, 1'b0, 1'b1, 1'b0, ALU_SUB, 1'b0, IMM_B};
            OP_JAL:    return '{1'b1, RS_PC4, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b0, IMM_J};
            OP_JALR:   return '{1'b1, RS_PC4, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b1, IMM_I};
            OP_LUI,
            OP_AUIPC:  return '{1'b1, RS_ALU, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1, IMM_U};
            default:   return '0;
        endcase
    endfunction

    function automatic logic [31:0] imm_ext(input logic [31:0] i, input logic [2:0] src);
        return src == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
               src == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
               src == IMM_J ? {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0} :
               src == IMM_U ? {i[31:12], 12'b0} : {{20{i[31]}}, i[31:20]};
    endfunction
endpackage

// File: rtl/decode_stage_pipe_if.sv
// decode_stage_pipe_if: decode-side inputs and execute-side outputs of the decode stage
interface decode_stage_pipe_if #(parameter int XLEN = 32, parameter int NREG = 32);
    localparam int AW = $clog2(NREG);
    logic [31:0]     InstrD;
    logic            ValidD;
    logic [XLEN-1:0] PCD, PCPlus4D;
    logic            RegWriteW;
    logic [AW-1:0]   RD_W;
    logic [XLEN-1:0] ResultW;
    logic            StallE, FlushE;
    logic            RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [AW-1:0]   RD_E, RS1_E, RS2_E;
    logic            ValidE, LoadUseStallD;

    modport master (
        output InstrD, ValidD, PCD, PCPlus4D, RegWriteW, RD_W, ResultW, StallE, FlushE,
        input  RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E, ValidE, LoadUseStallD
    );
    modport slave (
        input  InstrD, ValidD, PCD, PCPlus4D, RegWriteW, RD_W, ResultW, StallE, FlushE,
        output RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ResultSrcE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E, ValidE, LoadUseStallD
    );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: NREG x XLEN register file, x0 fixed at zero, optional write-through to both read ports
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    logic [XLEN-1:0] rf [NREG];
    logic wr;

    assign wr = we && wa != '0;

    always_ff @(posedge clk or posedge rst)
        if (rst) rf <= '{default: '0};
        else if (wr) rf[wa] <= wd;

    assign rd1 = (BYPASS != 0 && wr && wa == ra1) ? wd : rf[ra1];
    assign rd2 = (BYPASS != 0 && wr && wa == ra2) ? wd : rf[ra2];
endmodule

// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: register read, control/immediate decode, ID/EX register and load-use detection
module decode_stage_pipe import decode_pkg::*; #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int BYPASS = 1
) (
    input logic                clk,
    input logic                rst,
    decode_stage_pipe_if.slave bus
);
    localparam int AW = $clog2(NREG);
    localparam int W = 11 + 5 * XLEN + 3 * AW;

    logic [AW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm;
    logic [W-1:0]    e_d, e_q;
    logic            v;
    ctrl_t           c;

    assign rs1 = bus.InstrD[15 +: AW];
    assign rs2 = bus.InstrD[20 +: AW];
    assign rd  = bus.InstrD[7 +: AW];
    assign v   = bus.ValidD;
    assign c   = decode(bus.InstrD);
    assign imm = XLEN'($signed(imm_ext(bus.InstrD, c.imm_src)));

    regfile_bypass #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
        .clk(clk), .rst(rst), .ra1(rs1), .ra2(rs2),
        .we(bus.RegWriteW), .wa(bus.RD_W), .wd(bus.ResultW), .rd1(rd1), .rd2(rd2)
    );

    // Whole ID/EX slot as one vector so flush, stall and load act on every field alike
    assign e_d = {c.reg_write & v, c.result_src, c.mem_write & v, c.branch & v, c.jump & v,
                  c.alu_ctrl, c.alu_src, rd1, rd2, imm, bus.PCD, bus.PCPlus4D, rd, rs1, rs2, v};

    always_ff @(posedge clk or posedge rst)
        if (rst) e_q <= '0;
        else if (bus.FlushE) e_q <= '0;
        else if (!bus.StallE) e_q <= e_d;

    assign {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.BranchE, bus.JumpE, bus.ALUControlE,
            bus.ALUSrcE, bus.RD1_E, bus.RD2_E, bus.Imm_Ext_E, bus.PCE, bus.PCPlus4E,
            bus.RD_E, bus.RS1_E, bus.RS2_E, bus.ValidE} = e_q;

    assign bus.LoadUseStallD = bus.ValidE && bus.ResultSrcE == RS_MEM && bus.RD_E != '0 &&
                               (bus.RD_E == rs1 || bus.RD_E == rs2) && bus.ValidD;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed scenarios plus randomized run against an instruction-level reference model
module tb_decode_stage_pipe;
    import decode_pkg::*;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw, br, jp;
        logic [2:0]  alu;
        logic        asrc;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rd, rs1, rs2;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.XLEN(32), .NREG(32)) b0 ();
    decode_stage_pipe_if #(.XLEN(32), .NREG(32)) b1 ();
    decode_stage_pipe_if #(.XLEN(32), .NREG(16)) b2 ();

    decode_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
    decode_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    decode_stage_pipe #(.XLEN(32), .NREG(16), .BYPASS(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

    assign b1.InstrD = b0.InstrD;       assign b2.InstrD = b0.InstrD;
    assign b1.ValidD = b0.ValidD;       assign b2.ValidD = b0.ValidD;
    assign b1.PCD = b0.PCD;             assign b2.PCD = b0.PCD;
    assign b1.PCPlus4D = b0.PCPlus4D;   assign b2.PCPlus4D = b0.PCPlus4D;
    assign b1.RegWriteW = b0.RegWriteW; assign b2.RegWriteW = b0.RegWriteW;
    assign b1.RD_W = b0.RD_W;           assign b2.RD_W = b0.RD_W[3:0];
    assign b1.ResultW = b0.ResultW;     assign b2.ResultW = b0.ResultW;
    assign b1.StallE = b0.StallE;       assign b2.StallE = b0.StallE;
    assign b1.FlushE = b0.FlushE;       assign b2.FlushE = b0.FlushE;

    logic [185:0] out0;
    assign out0 = {b0.RegWriteE, b0.ResultSrcE, b0.MemWriteE, b0.BranchE, b0.JumpE, b0.ALUControlE,
                   b0.ALUSrcE, b0.RD1_E, b0.RD2_E, b0.Imm_Ext_E, b0.PCE, b0.PCPlus4E,
                   b0.RD_E, b0.RS1_E, b0.RS2_E, b0.ValidE};

    int vecs = 0;
    int errs = 0;
    logic [31:0] regs [32];

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLT;
            3'd4:    return ALU_XOR;
            3'd5:    return ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] srand(input int span);
        int x;
        x = int'($urandom_range(0, 2 * span - 1)) - span;
        return x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] ins, input logic v);
        b0.InstrD = ins;
        b0.ValidD = v;
        b0.PCD = 32'h100;
        b0.PCPlus4D = 32'h104;
    endtask

    task automatic set_w(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        b0.RegWriteW = we;
        b0.RD_W = rd;
        b0.ResultW = wd;
    endtask

    task automatic gen(output logic [31:0] ins, output exp_t g);
        int t;
        logic [4:0] a, b, d;
        logic [2:0] f3;
        logic [31:0] imm;
        logic [6:0] bad [3];
        bad = '{7'b1111111, 7'b0001111, 7'b1110011};
        t = $urandom_range(0, 9);
        a = 5'($urandom);
        b = 5'($urandom);
        d = 5'($urandom);
        f3 = 3'($urandom);
        g = '0;
        imm = srand(2048);
        case (t)
            0: begin ins = enc_i(imm, a, f3, d, OP_R);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_ALU, 3'b000, alu_of(f3, imm[10]), 1'b0}; end
            1: begin ins = enc_i(imm, a, f3, d, OP_I);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_ALU, 3'b000, alu_of(f3, 1'b0), 1'b1}; end
            2: begin ins = enc_i(imm, a, f3, d, OP_LOAD);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_MEM, 3'b000, ALU_ADD, 1'b1}; end
            3: begin ins = enc_s(imm, b, a, f3);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b0, RS_ALU, 3'b100, ALU_ADD, 1'b1}; end
            4: begin imm = srand(2048) * 2; ins = enc_b(imm, b, a, f3);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b0, RS_ALU, 3'b010, ALU_SUB, 1'b0}; end
            5: begin imm = srand(524288) * 2; ins = enc_j(imm, d);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_PC4, 3'b001, ALU_ADD, 1'b0}; end
            6: begin ins = enc_i(imm, a, 3'b000, d, OP_JALR);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_PC4, 3'b001, ALU_ADD, 1'b1}; end
            7: begin imm = $urandom & 32'hFFFFF000; ins = enc_u(imm, d, OP_LUI);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_ALU, 3'b000, ALU_ADD, 1'b1}; end
            8: begin imm = $urandom & 32'hFFFFF000; ins = enc_u(imm, d, OP_AUIPC);
                {g.rw, g.rsrc, g.mw, g.br, g.jp, g.alu, g.asrc} = {1'b1, RS_ALU, 3'b000, ALU_ADD, 1'b1}; end
            default: ins = enc_i(imm, a, f3, d, bad[$urandom_range(0, 2)]);
        endcase
        g.imm = imm;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (out0 !== '0 || b0.LoadUseStallD !== 1'b0) begin
            errs++; $display("FAIL reset_state: got out=%h lu=%b, want all 0", out0, b0.LoadUseStallD);
        end
        rst = 1'b0;
        set_w(1'b1, 5'd5, 32'h55);
        set_d(enc_i(32'd7, 5'd0, 3'd0, 5'd1, OP_I), 1'b1);
        tick;
        vecs++;
        if (b0.ValidE !== 1'b1) begin errs++; $display("FAIL reset_prefill: ValidE=%b want 1", b0.ValidE); end
        set_w(1'b0, 5'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        vecs++;
        if (out0 !== '0 || b0.LoadUseStallD !== 1'b0) begin
            errs++; $display("FAIL reset_async: got out=%h lu=%b, want all 0", out0, b0.LoadUseStallD);
        end
        set_d(enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd6), 1'b1);
        #1 rst = 1'b0;
        tick;
        vecs++;
        if ({b0.RD1_E, b0.RD2_E, b0.ValidE} !== {64'd0, 1'b1}) begin
            errs++; $display("FAIL reset_regfile: x5 rd1=%h rd2=%h valid=%b, want 0 0 1", b0.RD1_E, b0.RD2_E, b0.ValidE);
        end
    endtask

    task automatic test_bypass;
        set_w(1'b1, 5'd5, 32'hDEADBEEF);
        set_d(enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd6), 1'b1);
        tick;
        vecs++;
        if ({b0.RD1_E, b0.RD2_E} !== {2{32'hDEADBEEF}}) begin
            errs++; $display("FAIL bypass_on: rd1=%h rd2=%h want deadbeef", b0.RD1_E, b0.RD2_E);
        end
        vecs++;
        if ({b1.RD1_E, b1.RD2_E} !== 64'd0) begin
            errs++; $display("FAIL bypass_off: rd1=%h rd2=%h want 0", b1.RD1_E, b1.RD2_E);
        end
        set_w(1'b0, 5'd0, 32'd0);
        tick;
        vecs++;
        if (b1.RD1_E !== 32'hDEADBEEF) begin errs++; $display("FAIL write_visible: rd1=%h want deadbeef", b1.RD1_E); end
    endtask

    task automatic test_x0;
        set_w(1'b1, 5'd0, 32'h1234);
        set_d(enc_r(7'd0, 5'd0, 5'd0, 3'd0, 5'd7), 1'b1);
        tick;
        vecs++;
        if ({b0.RD1_E, b1.RD1_E} !== 64'd0) begin
            errs++; $display("FAIL x0_bypass: rd1=%h/%h want 0", b0.RD1_E, b1.RD1_E);
        end
        set_w(1'b0, 5'd0, 32'd0);
        tick;
        vecs++;
        if ({b0.RD1_E, b1.RD2_E} !== 64'd0) begin
            errs++; $display("FAIL x0_write: rd1=%h rd2=%h want 0", b0.RD1_E, b1.RD2_E);
        end
    endtask

    task automatic test_flush_stall;
        set_d(enc_i(32'd7, 5'd0, 3'd0, 5'd1, OP_I), 1'b1);
        tick;
        vecs++;
        if ({b0.Imm_Ext_E, b0.ValidE, b0.RegWriteE} !== {32'd7, 2'b11}) begin
            errs++; $display("FAIL load_addi: imm=%h v=%b rw=%b want 7 1 1", b0.Imm_Ext_E, b0.ValidE, b0.RegWriteE);
        end
        b0.StallE = 1'b1;
        set_d(enc_i(32'd99, 5'd0, 3'd0, 5'd2, OP_I), 1'b1);
        tick;
        tick;
        vecs++;
        if ({b0.Imm_Ext_E, b0.RD_E} !== {32'd7, 5'd1}) begin
            errs++; $display("FAIL stall_hold: imm=%h rd=%0d want 7 1", b0.Imm_Ext_E, b0.RD_E);
        end
        b0.FlushE = 1'b1;
        tick;
        vecs++;
        if (out0 !== '0) begin errs++; $display("FAIL flush_wins: out=%h want 0", out0); end
        b0.StallE = 1'b0;
        b0.FlushE = 1'b0;
    endtask

    task automatic test_load_use;
        set_d(enc_i(32'd0, 5'd2, 3'd2, 5'd3, OP_LOAD), 1'b1);
        tick;
        set_d(enc_r(7'd0, 5'd1, 5'd3, 3'd0, 5'd4), 1'b1);
        #1;
        vecs++;
        if (b0.LoadUseStallD !== 1'b1) begin errs++; $display("FAIL lu_rs1: got %b want 1", b0.LoadUseStallD); end
        b0.FlushE = 1'b1;
        #1;
        vecs++;
        if (b0.LoadUseStallD !== 1'b1) begin errs++; $display("FAIL lu_flush_indep: got %b want 1", b0.LoadUseStallD); end
        b0.FlushE = 1'b0;
        set_d(enc_r(7'd0, 5'd3, 5'd1, 3'd0, 5'd4), 1'b1);
        #1;
        vecs++;
        if (b0.LoadUseStallD !== 1'b1) begin errs++; $display("FAIL lu_rs2: got %b want 1", b0.LoadUseStallD); end
        b0.ValidD = 1'b0;
        #1;
        vecs++;
        if (b0.LoadUseStallD !== 1'b0) begin errs++; $display("FAIL lu_bubble: got %b want 0", b0.LoadUseStallD); end
        set_d(enc_i(32'd0, 5'd2, 3'd2, 5'd0, OP_LOAD), 1'b1);
        tick;
        set_d(enc_r(7'd0, 5'd1, 5'd0, 3'd0, 5'd4), 1'b1);
        #1;
        vecs++;
        if (b0.LoadUseStallD !== 1'b0) begin errs++; $display("FAIL lu_rd_x0: got %b want 0", b0.LoadUseStallD); end
        set_d(enc_i(32'd1, 5'd0, 3'd0, 5'd3, OP_I), 1'b1);
        tick;
        set_d(enc_r(7'd0, 5'd1, 5'd3, 3'd0, 5'd4), 1'b1);
        #1;
        vecs++;
        if (b0.LoadUseStallD !== 1'b0) begin errs++; $display("FAIL lu_not_load: got %b want 0", b0.LoadUseStallD); end
    endtask

    task automatic test_rv32e;
        set_w(1'b1, 5'd15, 32'hA5A5A5A5);
        set_d(enc_i(32'd0, 5'd0, 3'd0, 5'd0, OP_I), 1'b1);
        tick;
        set_w(1'b0, 5'd0, 32'd0);
        set_d(enc_r(7'd0, 5'd0, 5'd15, 3'd0, 5'd1), 1'b1);
        tick;
        vecs++;
        if ({b2.RD1_E, b2.RS1_E} !== {32'hA5A5A5A5, 4'd15}) begin
            errs++; $display("FAIL rv32e_x15: rd1=%h rs1=%0d want a5a5a5a5 15", b2.RD1_E, b2.RS1_E);
        end
        set_d(enc_b(-32'sd3000, 5'd2, 5'd1, 3'd0), 1'b1);
        tick;
        vecs++;
        if ({b2.BranchE, b2.RegWriteE, b2.Imm_Ext_E} !== {2'b10, 32'hFFFFF448}) begin
            errs++; $display("FAIL rv32e_beq: br=%b rw=%b imm=%h want 1 0 fffff448", b2.BranchE, b2.RegWriteE, b2.Imm_Ext_E);
        end
    endtask

    task automatic test_random;
        logic [31:0] ins, wd, e1_rd1, e1_rd2;
        logic [4:0] rdw;
        logic we, lu;
        exp_t g, em;
        set_w(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        em = '0;
        e1_rd1 = '0;
        e1_rd2 = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int n = 0; n < 600; n++) begin
            gen(ins, g);
            b0.InstrD = ins;
            b0.ValidD = $urandom_range(0, 3) != 0;
            b0.PCD = $urandom & 32'hFFFFFFFC;
            b0.PCPlus4D = b0.PCD + 32'd4;
            we = 1'($urandom);
            rdw = 5'($urandom);
            wd = $urandom;
            set_w(we, rdw, wd);
            b0.StallE = $urandom_range(0, 7) == 0;
            b0.FlushE = $urandom_range(0, 7) == 0;
            #1;
            lu = em.v && em.rsrc == 2'b01 && em.rd != 0 && (em.rd == ins[19:15] || em.rd == ins[24:20]) && b0.ValidD;
            vecs++;
            if (b0.LoadUseStallD !== lu) begin
                errs++; $display("FAIL rand_loaduse[%0d]: got %b want %b", n, b0.LoadUseStallD, lu);
            end
            if (b0.FlushE) begin
                em = '0;
                e1_rd1 = '0;
                e1_rd2 = '0;
            end else if (!b0.StallE) begin
                {g.rw, g.mw, g.br, g.jp} = {g.rw, g.mw, g.br, g.jp} & {4{b0.ValidD}};
                g.rd1 = (we && rdw != 0 && rdw == ins[19:15]) ? wd : regs[ins[19:15]];
                g.rd2 = (we && rdw != 0 && rdw == ins[24:20]) ? wd : regs[ins[24:20]];
                g.pc = b0.PCD;
                g.pc4 = b0.PCPlus4D;
                {g.rd, g.rs1, g.rs2} = {ins[11:7], ins[19:15], ins[24:20]};
                g.v = b0.ValidD;
                e1_rd1 = regs[ins[19:15]];
                e1_rd2 = regs[ins[24:20]];
                em = g;
            end
            if (we && rdw != 0) regs[rdw] = wd;
            tick;
            vecs++;
            if (out0 !== em) begin errs++; $display("FAIL rand_idex[%0d]: got %h want %h", n, out0, em); end
            vecs++;
            if ({b1.RD1_E, b1.RD2_E} !== {e1_rd1, e1_rd2}) begin
                errs++; $display("FAIL rand_nobypass[%0d]: got %h %h want %h %h", n, b1.RD1_E, b1.RD2_E, e1_rd1, e1_rd2);
            end
        end
        b0.StallE = 1'b0;
        b0.FlushE = 1'b0;
    endtask

    initial begin
        set_d(32'd0, 1'b0);
        set_w(1'b0, 5'd0, 32'd0);
        b0.StallE = 1'b0;
        b0.FlushE = 1'b0;
        test_reset;
        test_bypass;
        test_x0;
        test_flush_stall;
        test_load_use;
        test_rv32e;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
